// File: rtl/sync_fifo_dpram_if.sv
// sync_fifo_dpram handshake bundle: write/read requests, read data, flags.
// master drives requests (producer/consumer side), slave is the FIFO.
interface sync_fifo_dpram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              In_Wen;
  logic [DATA_W-1:0] In_Wdata;
  logic              In_Ren;
  logic              In_ClrErr;
  logic [DATA_W-1:0] Out_Rdata;
  logic              Out_Rvalid;
  logic              Out_Full;
  logic              Out_Empty;
  logic              Out_AFull;
  logic              Out_AEmpty;
  logic [ADDR_W:0]   Out_Level;
  logic              Out_Ovf;
  logic              Out_Udf;

  modport master (
    output In_Wen, In_Wdata, In_Ren, In_ClrErr,
    input  Out_Rdata, Out_Rvalid,
    input  Out_Full, Out_Empty,
    input  Out_AFull, Out_AEmpty,
    input  Out_Level, Out_Ovf, Out_Udf
  );

  modport slave (
    input  In_Wen, In_Wdata, In_Ren, In_ClrErr,
    output Out_Rdata, Out_Rvalid,
    output Out_Full, Out_Empty,
    output Out_AFull, Out_AEmpty,
    output Out_Level, Out_Ovf, Out_Udf
  );
endinterface

// File: rtl/sync_fifo_dpram.sv
// Single-clock FIFO on an inferred simple dual-port RAM.
// Ports: In_Clk, In_Rst (sync, active high), bus (slave: req/data/flags).
module sync_fifo_dpram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4
) (
  input logic             In_Clk,
  input logic             In_Rst,
  sync_fifo_dpram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LW    = ADDR_W + 1;

  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L   = LW'(AFULL_TH);
  localparam logic [LW-1:0] AE_L   = LW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_nxt;

  logic              full_q;
  logic              empty_q;
  logic              afull_q;
  logic              aempty_q;
  logic              ovf_q;
  logic              udf_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic wr_acc;
  logic rd_acc;

  assign wr_acc = bus.In_Wen & ~full_q;
  assign rd_acc = bus.In_Ren & ~empty_q;

  always_comb begin
    level_nxt = level_q;
    unique case (1'b1)
      wr_acc & ~rd_acc: level_nxt = level_q + 1'b1;
      rd_acc & ~wr_acc: level_nxt = level_q - 1'b1;
      default: ;
    endcase
  end

  // RAM array has no reset so it maps onto block RAM.
  always_ff @(posedge In_Clk) begin
    if (!In_Rst && wr_acc) begin
      mem[wr_ptr_q] <= bus.In_Wdata;
    end
  end

  always_ff @(posedge In_Clk) begin
    if (In_Rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge In_Clk) begin
    if (In_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // Flags follow the next level so they agree with Out_Level.
      level_q  <= level_nxt;
      full_q   <= (level_nxt == FULL_L);
      empty_q  <= (level_nxt == '0);
      afull_q  <= (level_nxt >= AF_L);
      aempty_q <= (level_nxt <= AE_L);
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge In_Clk) begin
    if (In_Rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.In_Wen & full_q)
             | (ovf_q & ~bus.In_ClrErr);
      udf_q <= (bus.In_Ren & empty_q)
             | (udf_q & ~bus.In_ClrErr);
    end
  end

  assign bus.Out_Rdata  = rdata_q;
  assign bus.Out_Rvalid = rvalid_q;
  assign bus.Out_Full   = full_q;
  assign bus.Out_Empty  = empty_q;
  assign bus.Out_AFull  = afull_q;
  assign bus.Out_AEmpty = aempty_q;
  assign bus.Out_Level  = level_q;
  assign bus.Out_Ovf    = ovf_q;
  assign bus.Out_Udf    = udf_q;
endmodule
